// File: rtl/gate_sweep_checker.sv
// Self-test sweeper for the three-input gate cell: walks all eight A/B/C vectors,
// samples X (and Y when GATE_SWEEP_CHECK_Y_EN is defined) and reports failures.
module gate_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ERR_W   = 4;
    localparam int unsigned NVEC    = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   abc_nxt;
    logic               busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic [NVEC-1:0]    fail_nxt;
    logic               exp_x, exp_y;
    logic               vec_bad;

    // Golden cell function for the vector currently on the cell inputs
    assign exp_x = (idx[2] & idx[1]) | ~idx[0];
    assign exp_y = ~idx[0];

`ifdef GATE_SWEEP_CHECK_Y_EN
    assign vec_bad = (x_in != exp_x) || (y_in != exp_y);
`else
    logic unused_y;
    assign unused_y = y_in ^ exp_y;
    assign vec_bad  = (x_in != exp_x);
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            c_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            a_out     <= abc_nxt[2];
            b_out     <= abc_nxt[1];
            c_out     <= abc_nxt[0];
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        abc_nxt   = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pass_nxt  = pass;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SETTLE;
                    idx_nxt   = '0;
                    cnt_nxt   = CNT_LOAD;
                    fail_nxt  = '0;
                    err_nxt   = '0;
                    pass_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end

            S_SETTLE: begin
                busy_nxt = 1'b1;
                abc_nxt  = idx;
                if (cnt == '0) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                if (vec_bad) begin
                    fail_nxt[idx] = 1'b1;
                    err_nxt       = err_count + ERR_W'(1);
                end
                if (idx == IDX_LAST) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    state_nxt = S_SETTLE;
                    idx_nxt   = idx + IDX_W'(1);
                    cnt_nxt   = CNT_LOAD;
                    busy_nxt  = 1'b1;
                    abc_nxt   = idx + IDX_W'(1);
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
